// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM/grant types and default widths for the RAM port scheduler
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 18;
  localparam int HALF_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} ram_arb_state_t;
  typedef enum logic {GNT_IF, GNT_MEM} ram_arb_grant_t;
endpackage

// File: rtl/ram_port_scheduler_if.sv
// ram_port_scheduler_if: fetch and memory-stage requester handshakes plus busy status
interface ram_port_scheduler_if import ram_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int HALF_W = HALF_W_DEF
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ack;
  logic [2*HALF_W-1:0]   if_rdata;
  logic                  mem_req;
  logic                  mem_rw;
  logic [ADDR_W-1:0]     mem_addr;
  logic [2*HALF_W-1:0]   mem_wdata;
  logic                  mem_ack;
  logic [2*HALF_W-1:0]   mem_rdata;
  logic                  busy;
  modport master (
    output if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata, busy
  );
  modport slave (
    input  if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata,
    output if_ack, if_rdata, mem_ack, mem_rdata, busy
  );
endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select; RAM_ARB_RR_EN switches fixed memory priority to round-robin
module ram_arb_pick import ram_arb_pkg::*; (
  input  logic           if_req,
  input  logic           mem_req,
`ifdef RAM_ARB_RR_EN
  input  ram_arb_grant_t last,
`endif
  output ram_arb_grant_t win
);
`ifdef RAM_ARB_RR_EN
  // on a conflict the requester not served last wins; the result is only used when some req is high
  assign win = (mem_req && !(if_req && last == GNT_MEM)) ? GNT_MEM : GNT_IF;
`else
  // memory stage always beats fetch; the result is only used when some req is high
  assign win = (mem_req || !if_req) ? GNT_MEM : GNT_IF;
`endif
endmodule

// File: rtl/ram_port_scheduler.sv
// ram_port_scheduler: serves 32-bit words from a 16-bit SRAM as two halfword cycles per requester; RAM_ARB_RR_EN enables round-robin arbitration
module ram_port_scheduler import ram_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int HALF_W = HALF_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  ram_port_scheduler_if.slave bus,
  output logic [ADDR_W-1:0]   ram_addr,
  inout  wire  [HALF_W-1:0]   ram_data,
  output logic                ram_wre
);
  localparam int WORD_W = 2 * HALF_W;
  ram_arb_state_t    state_q, state_d;
  ram_arb_grant_t    gnt_q, gnt_d, win;
  logic              rw_q, rw_d, oe_q, oe_d, wre_q, wre_d, busy_q, busy_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [HALF_W-1:0] whi_q, whi_d, rlo_q, rlo_d, dout_q, dout_d;
  logic [WORD_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
`ifdef RAM_ARB_RR_EN
  ram_arb_grant_t    last_q, last_d;
  ram_arb_pick u_pick (.if_req(bus.if_req), .mem_req(bus.mem_req), .last(last_q), .win(win));
`else
  ram_arb_pick u_pick (.if_req(bus.if_req), .mem_req(bus.mem_req), .win(win));
`endif
  // next-state and registered pin values for the IDLE -> LO -> HI -> DONE sequence
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rw_d = rw_q;
    oe_d = oe_q;
    wre_d = wre_q;
    busy_d = busy_q;
    base_d = base_q;
    addr_d = addr_q;
    whi_d = whi_q;
    rlo_d = rlo_q;
    dout_d = dout_q;
    if_rdata_d = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d = 1'b0;
    mem_ack_d = 1'b0;
`ifdef RAM_ARB_RR_EN
    last_d = last_q;
`endif
    case (state_q)
      IDLE: if (bus.if_req || bus.mem_req) begin
        state_d = LO;
        busy_d = 1'b1;
        gnt_d = win;
        rw_d = (win == GNT_MEM) && bus.mem_rw;
        base_d = ((win == GNT_MEM) ? bus.mem_addr : bus.if_addr) & ~ADDR_W'(1);
        addr_d = base_d;
        whi_d = bus.mem_wdata[WORD_W-1:HALF_W];
        dout_d = bus.mem_wdata[HALF_W-1:0];
        oe_d = rw_d;
        wre_d = !rw_d;
      end
      LO: begin
        state_d = HI;
        rlo_d = ram_data;
        addr_d = base_q | ADDR_W'(1);
        dout_d = whi_q;
      end
      HI: begin
        state_d = DONE;
        oe_d = 1'b0;
        wre_d = 1'b1;
        if_ack_d = (gnt_q == GNT_IF);
        mem_ack_d = (gnt_q == GNT_MEM);
        if (gnt_q == GNT_IF)
          if_rdata_d = {ram_data, rlo_q};
        else if (!rw_q)
          mem_rdata_d = {ram_data, rlo_q};
`ifdef RAM_ARB_RR_EN
        last_d = gnt_q;
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  // state and output registers; reset abandons any transaction in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q <= GNT_IF;
      rw_q <= 1'b0;
      oe_q <= 1'b0;
      wre_q <= 1'b1;
      busy_q <= 1'b0;
      base_q <= '0;
      addr_q <= '0;
      whi_q <= '0;
      rlo_q <= '0;
      dout_q <= '0;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
      if_ack_q <= 1'b0;
      mem_ack_q <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_q <= GNT_IF;
`endif
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rw_q <= rw_d;
      oe_q <= oe_d;
      wre_q <= wre_d;
      busy_q <= busy_d;
      base_q <= base_d;
      addr_q <= addr_d;
      whi_q <= whi_d;
      rlo_q <= rlo_d;
      dout_q <= dout_d;
      if_rdata_q <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q <= if_ack_d;
      mem_ack_q <= mem_ack_d;
`ifdef RAM_ARB_RR_EN
      last_q <= last_d;
`endif
    end
  end
  assign ram_addr = addr_q;
  assign ram_wre = wre_q;
  assign ram_data = oe_q ? dout_q : {HALF_W{1'bz}};
  assign bus.if_ack = if_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.mem_ack = mem_ack_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.busy = busy_q;
endmodule

// File: doc/ram_port_scheduler.md
# ram_port_scheduler

Sequencing arbiter sharing the single 16-bit external SRAM between the instruction-fetch requester and the memory-stage requester. Each requester issues 32-bit word transactions. The block splits every word into two halfword RAM cycles, drives address, data and write strobe, and returns a one-cycle acknowledge with the assembled read word. It sits between the pipeline stages and the RAM pins, on the fast clock.

## Interface
- `ADDR_W`, 18: RAM halfword address width.
- `HALF_W`, 16: RAM data width; the word width is 2*`HALF_W`.

- `clock` in 1: fast clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch read request; held until `if_ack`.
- `if_addr` in `ADDR_W`: fetch word base halfword address; bit 0 ignored.
- `if_ack` out 1: one-cycle pulse; `if_rdata` valid this cycle.
- `if_rdata` out 2*`HALF_W`: fetched word.
- `mem_req` in 1: memory-stage request; held until `mem_ack`.
- `mem_rw` in 1: 1 = write, 0 = read.
- `mem_addr` in `ADDR_W`: word base halfword address; bit 0 ignored.
- `mem_wdata` in 2*`HALF_W`: write word.
- `mem_ack` out 1: one-cycle pulse; `mem_rdata` valid this cycle for reads.
- `mem_rdata` out 2*`HALF_W`: read word.
- `ram_addr` out `ADDR_W`: SRAM address.
- `ram_data` inout `HALF_W`: SRAM data bus. Driven only during write halfword cycles; Z otherwise.
- `ram_wre` out 1: SRAM write enable, active-low.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states and transitions: IDLE -> LO -> HI -> DONE -> IDLE.
- **IDLE**
  - Evaluates the requests in each cycle.
  - If either request is high, selects a winner and latches its base address (bit 0 forced to 0), direction and write data. Fetch is always a read.
  - Moves to LO.
- **LO**
  - `ram_addr` = base.
  - Write: `ram_data` = wdata[15:0] and `ram_wre` = 0.
  - Read: captures `ram_data` into rdata[15:0] at the cycle-end edge.
- **HI**
  - `ram_addr` = base | 1.
  - Write: `ram_data` = wdata[31:16] and `ram_wre` = 0.
  - Read: captures rdata[31:16].
- **DONE**
  - Releases the bus and sets `ram_wre` = 1.
  - Pulses the winner's ack with rdata valid.
  - Returns to IDLE.
- Arbitration with both requests high in IDLE: `mem_req` wins (fixed priority). The loser stays pending and is granted on the next IDLE.
- Requesters deassert req on the edge where they sample ack high. A req still high in the following IDLE is a new transaction.
- `if_rdata` and `mem_rdata` are registered. They hold their last value until the next ack to the same requester.
- Changes on a granted requester's inputs after the grant are ignored until DONE.

## Timing
- Reset values (asynchronous):
  - state IDLE; `busy` 0.
  - `if_ack` and `mem_ack` 0.
  - `if_rdata` and `mem_rdata` 0.
  - `ram_addr` 0; `ram_wre` 1; `ram_data` Z.
  - Latched grant cleared.
- Latency: req seen in IDLE at cycle 0 -> LO cycle 1 -> HI cycle 2 -> ack in cycle 3.
- Throughput: one word per 4 cycles. A back-to-back requester receives an ack every 4 cycles.
- `ram_wre` is low for exactly the LO and HI cycles of a write, never in IDLE or DONE. The bus is driven only in those same cycles.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. A partially written word in RAM is acceptable.
- The requester re-issues after reset.

## Configuration
- `RAM_ARB_RR_EN`:
  - **Defined:** round-robin on simultaneous requests; the requester not served last wins. The last-served register resets to fetch, so the first conflict goes to memory.
  - **Undefined:** fixed memory-stage priority; the last-served register is absent.
  - Single-requester behaviour is identical in both builds.

## Structure
- Package `ram_arb_pkg` holds:
  - State enum `ram_arb_state_t` (IDLE, LO, HI, DONE).
  - Grant enum `ram_arb_grant_t` (GNT_IF, GNT_MEM).
  - Default width constants.
- Sub-module `ram_arb_pick`: combinational winner select from `if_req`, `mem_req` and the last-served grant. It holds the `RAM_ARB_RR_EN` logic.
- Top holds the FSM, latches, tri-state driver and output registers.

## Test plan
- **Fetch read.** Stimulus: `if_req` with `if_addr`=0x00010; RAM[0x10]=0x1234, RAM[0x11]=0xABCD. Required response:
  - `ram_addr` 0x10 then 0x11.
  - `if_ack` in cycle 3 with `if_rdata`=0xABCD1234.
  - `ram_wre` stays 1.
- **Memory write.** Stimulus: `mem_rw`=1, `mem_addr`=0x00021 (odd), `mem_wdata`=0xDEADBEEF. Required response:
  - Writes 0xBEEF at 0x20 and 0xDEAD at 0x21.
  - `ram_wre`=0 for exactly 2 cycles.
  - `mem_ack` in cycle 3; bus Z afterwards.
- **Simultaneous requests, fixed build.** Stimulus: both reqs high in the same IDLE. Required response:
  - `mem_ack` at cycle 3.
  - `if_ack` at cycle 7.
  - `if_rdata` unchanged before cycle 7.
- **Continuous requests, `RAM_ARB_RR_EN` build.** Stimulus: both reqs held continuously. Required response: acks alternate mem, if, mem, if at cycles 3, 7, 11, 15.
- **Reset mid-transaction.** Stimulus: assert `reset` during HI of a write. Required response:
  - Immediately `ram_wre`=1, bus Z, `busy`=0.
  - No ack; all rdata 0.
  - A new request after release completes normally.
